// File: rtl/sync_fifo_8x16.sv
// ============================================================================
// Module   : sync_fifo_8x16
// Purpose  : Single-clock byte FIFO, 16 deep, registered read and status flags
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_8x16 #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       data_count
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_dout;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [AW:0]       w_count_nxt;

  // Acceptance is gated by the registered flags only, so a full FIFO drops
  // the write and an empty FIFO ignores the read even when both are asserted.
  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_dout   <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign dout       = r_dout;
  assign full       = r_full;
  assign empty      = r_empty;
  assign data_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_8x16.sv
// ============================================================================
// Module   : tb_sync_fifo_8x16
// Purpose  : Directed and random stimulus with a queue-model scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_8x16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic [4:0] data_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;

  sync_fifo_8x16 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stimulus pushes accepted writes, a read pops the expected byte.
  always @(negedge reset_n) begin
    mq.delete();
    m_dout = 8'h00;
  end

  always begin
    logic wa, ra, rd_fire;
    @(posedge clk);
    rd_fire = 1'b0;
    if (reset_n) begin
      ra = rd_en && (mq.size() > 0);
      wa = wr_en && (mq.size() < 16);
      if (ra) begin
        m_dout  = mq.pop_front();
        rd_fire = 1'b1;
      end
      if (wa) mq.push_back(din);
    end
    #1;
    if (reset_n) begin
      chk(rd_fire ? "rd_data" : "dout_hold", 32'(dout), 32'(m_dout));
      chk("empty_flag", 32'(empty), 32'(mq.size() == 0));
      chk("full_flag", 32'(full), 32'(mq.size() == 16));
      chk("data_count", 32'(data_count), 32'(mq.size()));
    end
  end

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // 1. reset state and read while empty
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_count", 32'(data_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b1, 8'h00);
    chk("rd_empty_dout", 32'(dout), 32'h00);
    chk("rd_empty_flag", 32'(empty), 32'd1);

    // 2. single round trip
    step(1'b1, 1'b0, 8'hA5);
    chk("wr1_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    chk("rd1_dout", 32'(dout), 32'hA5);
    chk("rd1_empty", 32'(empty), 32'd1);

    // 3. fill, overflow write, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(data_count), 32'd16);
    step(1'b1, 1'b0, 8'hFF);
    chk("ovf_count", 32'(data_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // 4. pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_a_dout", 32'(dout), 32'h20 + 32'(i));
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
    chk("wrap_count", 32'(data_count), 32'd12);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_b_dout", 32'(dout), 32'h20 + 32'(i));
    end

    // 5a. simultaneous at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
    step(1'b1, 1'b1, 8'h35);
    chk("sim5_count", 32'(data_count), 32'd5);
    chk("sim5_dout", 32'(dout), 32'h30);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("sim5_order", 32'(dout), 32'h30 + 32'(i));
    end
    // 5b. simultaneous at full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
    step(1'b1, 1'b1, 8'hEE);
    chk("simf_count", 32'(data_count), 32'd15);
    chk("simf_full", 32'(full), 32'd0);
    chk("simf_dout", 32'(dout), 32'h40);
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    chk("simf_last", 32'(dout), 32'h4F);
    // 5c. simultaneous at empty: no bypass
    step(1'b1, 1'b1, 8'h55);
    chk("sime_count", 32'(data_count), 32'd1);
    chk("sime_dout", 32'(dout), 32'h4F);
    step(1'b0, 1'b1, 8'h00);
    chk("sime_rd", 32'(dout), 32'h55);

    // 6. asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_count", 32'(data_count), 32'd0);
    chk("arst_dout", 32'(dout), 32'h00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_dout", 32'(dout), 32'h77);
    chk("post_rst_empty", 32'(empty), 32'd1);

    // random soak, checked by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
